// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    // SYNC pattern, sent LSB-first: seven 0s then a 1 (KJKJKJKK on the line)
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Consecutive 1s allowed before a stuffed 0 is forced
    localparam int STUFF_LIMIT = 6;

    // Line states as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake between a packet source and the USB transmit encoder.
interface usb_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/usb_bit_timer.sv
// Bit-time generator: strobes on the first cycle of every USB bit while enabled.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    output logic bit_strobe
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    // Free-running 0..CLKS_PER_BIT-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count 0 marks a bit boundary; the first one follows enable immediately
    assign bit_strobe = en && (cnt == '0);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB 1.1 full-speed packet transmitter: SYNC, LSB-first data with bit
// stuffing, NRZI line coding and EOP, driven onto the D+/D- pair.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic    clk,
    input  logic    n_rst,
    usb_tx_if.slave bus,
    output logic    tx_busy,
    output logic    tx_done,
    output logic    tx_error,
    output logic    d_plus,
    output logic    d_minus
);

    tx_state_t  state, state_nx;
    logic       bit_strobe;
    logic       timer_en;

    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_full;
    logic       last_seen;      // final byte of the packet has been taken

    logic [7:0] shift_q;
    logic       cur_last;       // byte in the shift register ends the packet
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [2:0] ones_cnt, ones_nx;
    logic [1:0] line_q, line_nx; // doubles as the NRZI level register
    logic       aborted;

    logic       accept;
    logic       underrun;
    logic       finish;
    logic       ld_sync;
    logic       ld_data;
    logic       advance;
    logic       send;
    logic       send_bit;

    assign timer_en = (state != ST_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (timer_en),
        .bit_strobe (bit_strobe)
    );

    // Byte boundary reached with nothing to send and no final byte: abort.
    // Kept outside the FSM process so tx_ready can depend on it without a loop.
    assign underrun = bit_strobe && (state == ST_DATA) &&
                      (ones_cnt != 3'(STUFF_LIMIT)) && (bit_cnt == 4'd8) &&
                      !cur_last && !hold_full;

    assign bus.tx_ready = !hold_full && !last_seen && !underrun &&
                          (state inside {ST_IDLE, ST_SYNC, ST_DATA});
    assign accept       = bus.tx_valid && bus.tx_ready;

    assign d_plus  = line_q[1];
    assign d_minus = line_q[0];

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state, per-bit line symbol, stuffing and load decisions
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        ones_nx    = ones_cnt;
        line_nx    = line_q;
        ld_sync    = 1'b0;
        ld_data    = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        send       = 1'b0;
        send_bit   = 1'b1;
        unique case (state)
            ST_IDLE: begin
                line_nx    = LINE_J;
                bit_cnt_nx = '0;
                ones_nx    = '0;
                if (accept) state_nx = ST_SYNC;
            end
            ST_SYNC: if (bit_strobe) begin
                send     = 1'b1;
                send_bit = SYNC_BYTE[bit_cnt[2:0]];
                if (bit_cnt == 4'd7) begin
                    ld_sync    = 1'b1;
                    state_nx   = ST_DATA;
                    bit_cnt_nx = '0;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end
            ST_DATA: if (bit_strobe) begin
                if (ones_cnt == 3'(STUFF_LIMIT)) begin
                    // Stuffed 0: the shift register holds its place
                    send     = 1'b1;
                    send_bit = 1'b0;
                end else if (bit_cnt != 4'd8) begin
                    send       = 1'b1;
                    send_bit   = shift_q[0];
                    advance    = 1'b1;
                    bit_cnt_nx = bit_cnt + 4'd1;
                end else if (!cur_last && hold_full) begin
                    // Seamless refill: bit 0 of the next byte goes out now
                    ld_data    = 1'b1;
                    send       = 1'b1;
                    send_bit   = hold_data[0];
                    bit_cnt_nx = 4'd1;
                end else begin
                    // Normal end of packet or underrun abort
                    state_nx   = ST_EOP_SE0;
                    line_nx    = LINE_SE0;
                    bit_cnt_nx = '0;
                    ones_nx    = '0;
                end
            end
            ST_EOP_SE0: if (bit_strobe) begin
                if (bit_cnt == 4'd0) begin
                    bit_cnt_nx = 4'd1;
                end else begin
                    line_nx  = LINE_J;
                    state_nx = ST_EOP_J;
                end
            end
            ST_EOP_J: if (bit_strobe) begin
                finish   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // NRZI: a 0 toggles J/K, a 1 holds the level and extends the run of 1s
        if (send) begin
            line_nx = send_bit ? line_q : ((line_q == LINE_J) ? LINE_K : LINE_J);
            ones_nx = send_bit ? ones_cnt + 3'd1 : '0;
        end
    end

    // Bit counter, ones counter and registered line level
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
            line_q   <= LINE_J;
        end else begin
            bit_cnt  <= bit_cnt_nx;
            ones_cnt <= ones_nx;
            line_q   <= line_nx;
        end
    end

    // Holding register: a same-edge load and accept leaves it full with the new byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (ld_sync || ld_data) hold_full <= 1'b0;
            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= bus.tx_data;
                hold_last <= bus.tx_last;
            end
            if (finish)                     last_seen <= 1'b0;
            else if (accept && bus.tx_last) last_seen <= 1'b1;
        end
    end

    // Shift register, LSB leaves first
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q  <= '0;
            cur_last <= 1'b0;
        end else if (ld_sync) begin
            shift_q  <= hold_data;
            cur_last <= hold_last;
        end else if (ld_data) begin
            shift_q  <= {1'b0, hold_data[7:1]};
            cur_last <= hold_last;
        end else if (advance) begin
            shift_q  <= {1'b0, shift_q[7:1]};
        end
    end

    // Status outputs: busy spans the packet, done/error are single-cycle pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            tx_busy  <= (state != ST_IDLE) && !finish;
            tx_done  <= finish && !aborted;
            tx_error <= underrun;
            if (underrun)    aborted <= 1'b1;
            else if (finish) aborted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: table of packets with hand-computed
// spans and stuff counts, decoded back through a small NRZI/destuff model,
// plus sequences for line pattern, underrun, reset and back-to-back packets.
module tb_usb_tx_encoder;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tx_busy, tx_done, tx_error, d_plus, d_minus;
    int   cyc = 0;

    usb_tx_if bus();

    usb_tx_encoder #(
        .CLKS_PER_BIT (4)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .d_plus   (d_plus),
        .d_minus  (d_minus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         exp_span;
        int         exp_stuff;
    } vec_t;

    vec_t       vt [6];
    int         vecs = 0;
    int         errs = 0;
    logic [1:0] cap [$];
    logic [7:0] dec_q [$];
    int         acc_first;
    int         mon_t0;
    int         mon_tend;

    bit dn, er, sok, eok, fok;
    int sp, st, tend_a;
    logic [7:0] exp_b [3];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    task automatic drive(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input bit last_en, input bit keep_valid);
        logic [7:0] bs [3];
        int g;
        bit ok;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        for (int k = 0; k < n; k++) begin
            bus.tx_data  = bs[k];
            bus.tx_valid = 1'b1;
            bus.tx_last  = last_en && (k == n - 1);
            g = 0;
            ok = 0;
            while (g < 2000) begin
                if (!n_rst) break;
                if (bus.tx_ready) begin
                    @(posedge clk);
                    @(negedge clk);
                    ok = 1;
                    break;
                end
                @(negedge clk);
                g++;
            end
            if (!ok) begin
                bus.tx_valid = 1'b0;
                bus.tx_last  = 1'b0;
                if (n_rst) chk("drive_timeout", 0, 1);
                return;
            end
            if (k == 0) acc_first = cyc;
        end
        if (!keep_valid) begin
            bus.tx_valid = 1'b0;
            bus.tx_last  = 1'b0;
        end
    endtask

    task automatic monitor(output bit done_p, output bit err_p, output int span);
        int g;
        done_p = 0;
        err_p  = 0;
        span   = -1;
        cap.delete();
        g = 0;
        while (tx_busy !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (tx_busy !== 1'b1) begin
            chk("busy_rise_timeout", 0, 1);
            return;
        end
        mon_t0 = cyc;
        g = 0;
        while (g < 1000) begin
            if (tx_error) err_p = 1;
            if (tx_done)  done_p = 1;
            if (!tx_busy) break;
            if (((cyc - mon_t0) % 4) == 0) cap.push_back({d_plus, d_minus});
            @(negedge clk);
            g++;
        end
        if (g >= 1000) chk("busy_fall_timeout", 0, 1);
        span     = cyc - mon_t0;
        mon_tend = cyc;
    endtask

    // Receive-side model: NRZI decode, strip stuffed bits, assemble LSB-first bytes
    task automatic decode(output int stuffs, output bit sync_ok, output bit eop_ok, output bit frame_ok);
        logic       prev;
        logic       b;
        int         ones;
        int         bp;
        logic [7:0] acc;
        logic [7:0] sync_pat;
        sync_pat = 8'h80;
        prev = 1'b1;
        ones = 0;
        bp = 0;
        acc = '0;
        stuffs = 0;
        sync_ok = (cap.size() >= 8);
        eop_ok = 0;
        frame_ok = 1;
        dec_q.delete();
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i] == 2'b00) begin
                eop_ok = (i + 3 == cap.size()) && (cap[i+1] == 2'b00) && (cap[i+2] == 2'b10);
                if (bp != 0) frame_ok = 0;
                break;
            end
            if (cap[i] != 2'b10 && cap[i] != 2'b01) frame_ok = 0;
            b = (cap[i][1] == prev);
            prev = cap[i][1];
            if (ones == 6) begin
                stuffs++;
                if (b) frame_ok = 0;
                ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                if (i < 8) begin
                    if (b != sync_pat[i]) sync_ok = 0;
                end else begin
                    acc[bp] = b;
                    bp++;
                    if (bp == 8) begin
                        dec_q.push_back(acc);
                        bp = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string pat;
        logic [1:0] e;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.tx_last  = 1'b0;

        vt[0] = '{1, 8'h00, 8'h00, 8'h00,  76, 0};
        vt[1] = '{1, 8'hFF, 8'h00, 8'h00,  80, 1};
        vt[2] = '{1, 8'hFC, 8'h00, 8'h00,  80, 1};
        vt[3] = '{1, 8'h7F, 8'h00, 8'h00,  80, 1};
        vt[4] = '{3, 8'h3C, 8'hA5, 8'h7E, 144, 1};
        vt[5] = '{2, 8'hFF, 8'hFF, 8'h00, 116, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_d_plus",   d_plus, 1);
        chk("rst_d_minus",  d_minus, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_tx_busy",  tx_busy, 0);
        chk("rst_tx_done",  tx_done, 0);
        chk("rst_tx_error", tx_error, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            exp_b[0] = vt[v].b0; exp_b[1] = vt[v].b1; exp_b[2] = vt[v].b2;
            fork
                drive(vt[v].n, vt[v].b0, vt[v].b1, vt[v].b2, 1'b1, 1'b0);
                monitor(dn, er, sp);
            join
            decode(st, sok, eok, fok);
            chk($sformatf("v%0d_busy_latency", v), mon_t0 - acc_first, 1);
            chk($sformatf("v%0d_span", v), sp, vt[v].exp_span);
            chk($sformatf("v%0d_stuffs", v), st, vt[v].exp_stuff);
            chk($sformatf("v%0d_done", v), dn, 1);
            chk($sformatf("v%0d_error", v), er, 0);
            chk($sformatf("v%0d_sync", v), sok, 1);
            chk($sformatf("v%0d_eop", v), eok, 1);
            chk($sformatf("v%0d_frame", v), fok, 1);
            chk($sformatf("v%0d_nbytes", v), dec_q.size(), vt[v].n);
            for (int k = 0; k < vt[v].n && k < dec_q.size(); k++)
                chk($sformatf("v%0d_byte%0d", v, k), dec_q[k], exp_b[k]);
            repeat (3) @(negedge clk);
        end

        // Exact line pattern for a single 8'h00
        pat = "KJKJKJKKJKJKJKJK00J";
        fork
            drive(1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
            monitor(dn, er, sp);
        join
        chk("pat_len", cap.size(), pat.len());
        for (int i = 0; i < pat.len() && i < cap.size(); i++) begin
            e = (pat[i] == "K") ? 2'b01 : ((pat[i] == "J") ? 2'b10 : 2'b00);
            chk($sformatf("pat_sym%0d", i), cap[i], e);
        end
        chk("pat_idle_d_plus", d_plus, 1);
        chk("pat_idle_d_minus", d_minus, 0);
        repeat (3) @(negedge clk);

        // Underrun: second byte never offered
        fork
            drive(1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0);
            monitor(dn, er, sp);
        join
        decode(st, sok, eok, fok);
        chk("ur_error", er, 1);
        chk("ur_done", dn, 0);
        chk("ur_eop", eok, 1);
        chk("ur_span", sp, 76);
        chk("ur_nbytes", dec_q.size(), 1);
        if (dec_q.size() > 0) chk("ur_byte0", dec_q[0], 8'h5A);
        @(negedge clk);
        chk("ur_ready_idle", bus.tx_ready, 1);
        chk("ur_busy_idle", tx_busy, 0);
        repeat (3) @(negedge clk);

        // Reset asserted mid-DATA
        fork
            drive(3, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
            monitor(dn, er, sp);
            begin
                repeat (50) @(negedge clk);
                n_rst = 1'b0;
                #1;
                chk("mr_d_plus", d_plus, 1);
                chk("mr_d_minus", d_minus, 0);
                chk("mr_busy", tx_busy, 0);
                repeat (3) @(negedge clk);
                n_rst = 1'b1;
            end
        join
        chk("mr_no_done", dn, 0);
        chk("mr_no_error", er, 0);
        repeat (2) @(negedge clk);
        fork
            drive(1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
            monitor(dn, er, sp);
        join
        decode(st, sok, eok, fok);
        chk("mr_first_sym_k", (cap.size() > 0) ? cap[0] : 2'b11, 2'b01);
        chk("mr_sync", sok, 1);
        chk("mr_span", sp, 76);
        chk("mr_done", dn, 1);
        chk("mr_nbytes", dec_q.size(), 1);
        repeat (3) @(negedge clk);

        // tx_valid held high across the end of one packet into the next
        fork
            begin
                drive(1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
                drive(1, 8'hC3, 8'h00, 8'h00, 1'b1, 1'b0);
            end
            begin
                monitor(dn, er, sp);
                tend_a = mon_tend;
                decode(st, sok, eok, fok);
                chk("bb_a_span", sp, 76);
                chk("bb_a_done", dn, 1);
                chk("bb_a_nbytes", dec_q.size(), 1);
                monitor(dn, er, sp);
            end
        join
        decode(st, sok, eok, fok);
        chk("bb_b_accept_after_idle", acc_first - tend_a, 1);
        chk("bb_b_sync", sok, 1);
        chk("bb_b_span", sp, 76);
        chk("bb_b_done", dn, 1);
        chk("bb_b_nbytes", dec_q.size(), 1);
        if (dec_q.size() > 0) chk("bb_b_byte0", dec_q[0], 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

- USB 1.1 full-speed packet transmitter: accepts bytes over a valid/ready handshake and serialises them LSB-first.
- Prepends SYNC, applies bit stuffing and NRZI encoding, and finishes with EOP, driving the differential line pair.
- Transmit-side counterpart of the NRZI decode stage: packets it emits decode to the original bytes when looped back into the receive path.

## Interface
Parameters:
- CLKS_PER_BIT, 4, clock cycles per USB bit time (48 MHz clk → 12 Mb/s)

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset; one clock; reset is asynchronous and active-low
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data valid
- tx_last  input  1  qualifies tx_data as final byte of packet
- tx_ready  output  1  holding register empty; byte accepted on tx_valid && tx_ready
- tx_busy  output  1  packet in progress (any state but IDLE)
- tx_done  output  1  one-cycle pulse on normal packet completion
- tx_error  output  1  one-cycle pulse on underrun abort
- d_plus  output  1  D+ line
- d_minus  output  1  D− line

## Operation
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE:
  - Line is J (d_plus=1, d_minus=0).
  - First accepted byte goes into the holding register; FSM moves to SYNC.
- SYNC:
  - Sends 8'h80 LSB-first (seven 0s, then a 1).
  - At its last bit boundary, the shift register loads from the holding register; FSM moves to DATA.
- DATA:
  - Shifts one bit per bit time.
  - At each byte boundary: if the byte just sent had tx_last, go to EOP_SE0 (a pending stuff bit is still sent first). Otherwise load the next byte from the holding register.
  - If the holding register is empty at a byte boundary (underrun): pulse tx_error, go to EOP_SE0.
- NRZI:
  - Data 0 toggles the line between J and K; data 1 holds it.
  - The level register resets to J and is re-forced to J on entry to IDLE.
- Bit stuffing:
  - A counter tracks consecutive 1s sent, including SYNC's final 1.
  - After six 1s, the next bit slot is a stuffed 0 (line toggles), the counter clears, and the shift register does not advance.
  - Any transmitted 0 clears the counter.
- EOP_SE0: both lines 0 for 2 bit times.
- EOP_J: J for 1 bit time, then IDLE; tx_done pulses on that cycle unless the packet was aborted.
- tx_ready:
  - High whenever the holding register is empty, in any state except EOP_SE0 and EOP_J.
  - Bytes offered after the tx_last byte has been accepted are not accepted until IDLE.
- Reset mid-packet: immediate return to IDLE, J on the line, all counters and registers cleared, no tx_done or tx_error pulse.

## Timing
- Reset values:
  - d_plus=1, d_minus=0
  - tx_ready=1, tx_busy=0, tx_done=0, tx_error=0
  - FSM=IDLE; ones counter and bit timer 0
- Acceptance in IDLE at edge E0: first SYNC bit (K) is driven from edge E0+1. tx_busy rises at E0+1.
- Every bit, including stuffed and EOP bits, is held exactly CLKS_PER_BIT cycles. Line outputs are registered and change only at bit boundaries.
- Packet of N bytes with S stuffed bits occupies (8 + 8N + S + 3) × CLKS_PER_BIT cycles from E0+1. tx_done asserts the cycle after that span; tx_busy falls at the same edge.
- Holding-register refill window: a full byte time minus one cycle. A byte accepted on the boundary edge itself is not used for that boundary.
- tx_valid together with a byte-boundary load on the same edge: the load empties the register and the incoming byte is captured into it, with no loss.

## Structure
- Package usb_tx_pkg holds:
  - state enum
  - SYNC_BYTE = 8'h80
  - STUFF_LIMIT = 6
  - line-state constants J, K, SE0
- Sub-module usb_bit_timer: counter 0..CLKS_PER_BIT−1, enabled while busy, emits the bit_strobe used for all bit-boundary updates.
- Top level holds the FSM, holding register, shift register, bit counter, ones counter and NRZI level register.

## Test plan
- Single byte 8'h00 with tx_last:
  - Line must read SYNC K J K J K J K K.
  - Data J K J K J K J K.
  - Then SE0, SE0, J; tx_done pulses after (8+8+0+3)×4 = 76 cycles.
- Single byte 8'hFF: exactly one stuffed toggle after the fifth data 1 (six 1s counting SYNC). Span = 80 cycles.
- Three bytes 8'h3C, 8'hA5, 8'h7E, each offered as soon as tx_ready rises: no gaps between bytes. Loopback through the decode path must return the identical bytes.
- Second byte withheld past the first byte boundary: tx_error pulses, EOP follows, no tx_done, tx_ready high again in IDLE.
- n_rst asserted mid-DATA:
  - Outputs go to J immediately; tx_busy=0.
  - A new packet after release starts cleanly with SYNC K.
- tx_valid held high continuously across a packet end: the next packet begins only after IDLE, with a full SYNC.
